// File: rtl/apb_pkg.sv
// APB requester shared types: FSM state encoding, bus widths, response bundle.
// No logic of its own; imported by the bridge and its select decoder.
// Widths are fixed by the 8-select APB bus used by the slave models.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;
   localparam int APB_SEL_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_sel_decode.sv
// Address to one-hot slave select decode with out-of-range detection.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result on command accept.
module apb_sel_decode
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 8,
   parameter int SEL_LSB    = 28
) (
   input  logic [APB_ADDR_W-1:0] addr,
   output logic [APB_SEL_W-1:0]  sel,
   output logic                  decode_err
);

   logic [2:0] idx;

   assign idx = addr[SEL_LSB+2:SEL_LSB];

   // Select lines beyond the populated slave count are a decode error, not a bus cycle.
   always_comb begin
      sel        = '0;
      decode_err = ({29'd0, idx} >= NUM_SLAVES);
      if (!decode_err) begin
         sel[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB SETUP/ACCESS requester with timeout.
// Latency: accept->SETUP 1 cycle, ACCESS >=1 cycle, then a 1-cycle response pulse.
// Backpressure: cmd_ready is high only in IDLE; one transfer in flight at a time.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 8,
   parameter int SEL_LSB    = 28,
   parameter int TIMEOUT    = 16
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [APB_ADDR_W-1:0] cmd_addr,
   input  logic [APB_DATA_W-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [APB_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [APB_ADDR_W-1:0] paddr,
   output logic [APB_SEL_W-1:0]  pselx,
   output logic                  penable,
   output logic                  pwrite,
   output logic [APB_DATA_W-1:0] pwdata,
   input  logic [APB_DATA_W-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int CW = $clog2(TIMEOUT + 1);

   apb_state_e           state;
   logic [APB_SEL_W-1:0] sel_q;
   logic [CW-1:0]        wait_cnt;
   apb_rsp_t             rsp_q;
   logic [APB_SEL_W-1:0] dec_sel;
   logic                 dec_err;
   logic                 accept;

   apb_sel_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_LSB    (SEL_LSB)
   ) u_dec (
      .addr       (cmd_addr),
      .sel        (dec_sel),
      .decode_err (dec_err)
   );

   assign cmd_ready   = (state == IDLE);
   assign accept      = cmd_valid && cmd_ready;
   assign pselx       = ((state == SETUP) || (state == ACCESS)) ? sel_q : '0;
   assign penable     = (state == ACCESS);
   assign rsp_valid   = (state == RESP);
   assign rsp_rdata   = rsp_q.rdata;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

   // Sequence the transfer; rsp_q is only non-zero while RESP is presented.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         rsp_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (dec_err) begin
                     rsp_q <= '{rdata: '0, err: 1'b1, timeout: 1'b0};
                     state <= RESP;
                  end else begin
                     state <= SETUP;
                  end
               end
            end
            SETUP: begin
               wait_cnt <= CW'(1);
               state    <= ACCESS;
            end
            ACCESS: begin
               // pready is only meaningful here; the slave drops it once penable falls.
               if (pready) begin
                  rsp_q.rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                  rsp_q.err     <= pslverr;
                  rsp_q.timeout <= 1'b0;
                  state         <= RESP;
               end else if (wait_cnt == CW'(TIMEOUT)) begin
                  rsp_q <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            RESP: begin
               rsp_q <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Capture the command on accept; address/data/direction then hold until the next one.
   always_ff @(posedge pclk) begin
      if (preset) begin
         paddr  <= '0;
         pwrite <= 1'b0;
         pwdata <= '0;
         sel_q  <= '0;
      end else if (accept) begin
         paddr  <= cmd_addr;
         pwrite <= cmd_write;
         pwdata <= cmd_wdata;
         sel_q  <= dec_sel;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a one-wait-state APB slave model.
// Slave 2 answers with pslverr, slave 3 never asserts pready.
// A second bridge with four slaves exercises the decode-error path.
module tb_apb_master_bridge;

   logic        pclk;
   logic        preset;
   logic        cmd_valid, cmd_valid4;
   logic        cmd_ready, cmd_ready4;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_valid4;
   logic [31:0] rsp_rdata, rsp_rdata4;
   logic        rsp_err, rsp_err4;
   logic        rsp_timeout, rsp_timeout4;
   logic [31:0] paddr, paddr4;
   logic [7:0]  pselx, pselx4;
   logic        penable, penable4;
   logic        pwrite, pwrite4;
   logic [31:0] pwdata, pwdata4;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic [31:0] prdata4;
   logic        pready4, pslverr4;

   int n_vec = 0;
   int n_bad = 0;

   apb_master_bridge dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   apb_master_bridge #(.NUM_SLAVES(4)) dut4 (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
      .rsp_timeout(rsp_timeout4),
      .paddr(paddr4), .pselx(pselx4), .penable(penable4), .pwrite(pwrite4),
      .pwdata(pwdata4), .prdata(prdata4), .pready(pready4), .pslverr(pslverr4)
   );

   assign prdata4  = 32'h0;
   assign pready4  = 1'b0;
   assign pslverr4 = 1'b0;

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // ---------------- slave model: one wait state per access ----------------
   logic        wst;
   logic [31:0] mem [0:15];
   logic [15:0] mem_vld;

   always @(posedge pclk) wst <= penable;

   assign pready  = penable && wst && !pselx[3];
   assign pslverr = pready && pselx[2];

   always @* begin
      prdata = mem_vld[paddr[5:2]] ? mem[paddr[5:2]] : 32'h0012_3456;
   end

   always @(posedge pclk) begin
      if (preset) begin
         mem_vld <= '0;
      end else if (pready && pwrite && !pslverr) begin
         mem[paddr[5:2]]     <= pwdata;
         mem_vld[paddr[5:2]] <= 1'b1;
      end
   end

   // ---------------- accept / response monitor ----------------
   int cyc = 0;
   int acc_cnt = 0;
   int rsp_cnt = 0;
   int last_acc = 0;
   int prev_acc = 0;

   always @(posedge pclk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) begin
         acc_cnt  <= acc_cnt + 1;
         prev_acc <= last_acc;
         last_acc <= cyc;
      end
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one command and follow it to its response; lat counts negedges from
   // the accept edge up to and including the one where rsp_valid is seen.
   task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic tm, output logic [7:0] sel_seen, output int en_cnt);
      int guard;
      @(negedge pclk);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge pclk);
         guard++;
      end
      @(posedge pclk);
      lat = 0;
      sel_seen = '0;
      en_cnt = 0;
      do begin
         @(negedge pclk);
         if (lat == 0) cmd_valid = 1'b0;
         lat++;
         sel_seen |= pselx;
         en_cnt += int'(penable);
      end while (!rsp_valid && lat < 60);
      rd = rsp_rdata;
      er = rsp_err;
      tm = rsp_timeout;
   endtask

   int          lat, en_cnt, base, guard, nr;
   logic [31:0] rd;
   logic        er, tm;
   logic [7:0]  sel_seen;
   logic [31:0] r_rd [0:1];
   logic        r_er [0:1];
   logic        r_tm [0:1];
   bit          dropped;

   initial begin
      preset     = 1'b1;
      cmd_valid  = 1'b0;
      cmd_valid4 = 1'b0;
      cmd_write  = 1'b0;
      cmd_addr   = '0;
      cmd_wdata  = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      preset = 1'b0;

      // reset state
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_pselx",     32'(pselx),     32'd0);
      chk("rst_penable",   32'(penable),   32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_paddr",     paddr,          32'd0);

      // write then read back slave 0
      run_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, er, tm, sel_seen, en_cnt);
      chk("wr_lat",  32'(lat),      32'd4);
      chk("wr_sel",  32'(sel_seen), 32'h01);
      chk("wr_err",  32'(er),       32'd0);
      chk("wr_rd",   rd,            32'd0);
      chk("wr_en",   32'(en_cnt),   32'd2);

      run_cmd(1'b0, 32'h0000_0010, 32'h0, lat, rd, er, tm, sel_seen, en_cnt);
      chk("rd0_lat",  32'(lat),      32'd4);
      chk("rd0_sel",  32'(sel_seen), 32'h01);
      chk("rd0_data", rd,            32'hDEAD_BEEF);
      chk("rd0_err",  32'(er),       32'd0);
      @(negedge pclk);
      chk("rd0_vld_drop",  32'(rsp_valid), 32'd0);
      chk("rd0_data_drop", rsp_rdata,      32'd0);

      // unwritten location on slave 1
      run_cmd(1'b0, 32'h1000_0040, 32'h0, lat, rd, er, tm, sel_seen, en_cnt);
      chk("rd1_sel",  32'(sel_seen), 32'h02);
      chk("rd1_data", rd,            32'h0012_3456);
      chk("rd1_err",  32'(er),       32'd0);

      // decode error on the four-slave bridge
      @(negedge pclk);
      cmd_valid4 = 1'b1;
      cmd_write  = 1'b0;
      cmd_addr   = 32'h5000_0000;
      chk("dec_ready", 32'(cmd_ready4), 32'd1);
      @(negedge pclk);
      cmd_valid4 = 1'b0;
      chk("dec_vld",   32'(rsp_valid4),   32'd1);
      chk("dec_err",   32'(rsp_err4),     32'd1);
      chk("dec_tmo",   32'(rsp_timeout4), 32'd0);
      chk("dec_rdata", rsp_rdata4,        32'd0);
      chk("dec_sel",   32'(pselx4),       32'd0);
      @(negedge pclk);
      chk("dec_vld_drop", 32'(rsp_valid4), 32'd1 - 32'd1);
      chk("dec_sel2",     32'(pselx4),     32'd0);

      // timeout on slave 3
      run_cmd(1'b0, 32'h3000_0000, 32'h0, lat, rd, er, tm, sel_seen, en_cnt);
      chk("tmo_en_cycles", 32'(en_cnt),   32'd16);
      chk("tmo_lat",       32'(lat),      32'd18);
      chk("tmo_sel",       32'(sel_seen), 32'h08);
      chk("tmo_err",       32'(er),       32'd1);
      chk("tmo_flag",      32'(tm),       32'd1);
      chk("tmo_pselx",     32'(pselx),    32'd0);
      chk("tmo_penable",   32'(penable),  32'd0);

      // slave error followed by a held-valid back-to-back read
      @(negedge pclk);
      base      = acc_cnt;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h2000_0008;
      cmd_wdata = 32'h5555_AAAA;
      guard = 0;
      while (acc_cnt == base && guard < 50) begin
         @(negedge pclk);
         guard++;
      end
      cmd_write = 1'b0;
      cmd_addr  = 32'h0000_0010;
      nr = 0;
      guard = 0;
      while (nr < 2 && guard < 60) begin
         @(negedge pclk);
         guard++;
         if (acc_cnt == base + 2) cmd_valid = 1'b0;
         if (rsp_valid) begin
            r_rd[nr] = rsp_rdata;
            r_er[nr] = rsp_err;
            r_tm[nr] = rsp_timeout;
            nr++;
         end
      end
      repeat (6) @(negedge pclk);
      chk("b2b_rsp_cnt", 32'(nr),                  32'd2);
      chk("b2b_acc_cnt", 32'(acc_cnt - base),      32'd2);
      chk("b2b_spacing", 32'(last_acc - prev_acc), 32'd5);
      if (nr == 2) begin
         chk("slverr_err",  32'(r_er[0]), 32'd1);
         chk("slverr_tmo",  32'(r_tm[0]), 32'd0);
         chk("slverr_rd",   r_rd[0],      32'd0);
         chk("b2b_rd_data", r_rd[1],      32'hDEAD_BEEF);
         chk("b2b_rd_err",  32'(r_er[1]), 32'd0);
      end

      // reset in the middle of ACCESS
      base = rsp_cnt;
      @(negedge pclk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h3000_0004;
      guard = 0;
      while (!penable && guard < 20) begin
         @(negedge pclk);
         cmd_valid = 1'b0;
         guard++;
      end
      chk("mid_in_access", 32'(penable), 32'd1);
      @(negedge pclk);
      preset = 1'b1;
      @(negedge pclk);
      preset = 1'b0;
      chk("mid_pselx",     32'(pselx),     32'd0);
      chk("mid_penable",   32'(penable),   32'd0);
      chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      dropped = 1'b0;
      repeat (20) begin
         @(negedge pclk);
         if (rsp_valid) dropped = 1'b1;
      end
      chk("mid_no_rsp",    32'(dropped),          32'd0);
      chk("mid_rsp_count", 32'(rsp_cnt - base),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
